// File: rtl/fft16_sched.sv
// 16-point radix-4 FFT scheduler: frame buffer, two in-place stages driving an external butterfly, natural-order unload.
// Optional twiddle multiply between stages enabled by macro FFT16_SCHED_TWIDDLE_EN.
`timescale 1ns/1ps
module fft16_sched (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] in_re,
    input  logic signed [15:0] in_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_re,
    output logic signed [15:0] out_im,
    output logic [3:0]         out_idx,
    output logic               out_last,
    output logic signed [15:0] bf_a_re,
    output logic signed [15:0] bf_b_re,
    output logic signed [15:0] bf_c_re,
    output logic signed [15:0] bf_d_re,
    output logic signed [15:0] bf_a_im,
    output logic signed [15:0] bf_b_im,
    output logic signed [15:0] bf_c_im,
    output logic signed [15:0] bf_d_im,
    input  logic signed [15:0] bf_o0_re,
    input  logic signed [15:0] bf_o1_re,
    input  logic signed [15:0] bf_o2_re,
    input  logic signed [15:0] bf_o3_re,
    input  logic signed [15:0] bf_o0_im,
    input  logic signed [15:0] bf_o1_im,
    input  logic signed [15:0] bf_o2_im,
    input  logic signed [15:0] bf_o3_im,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_S1     = 2'd1,
        ST_S2     = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [3:0]         cnt_r;
    logic [3:0]         j_r;
    logic               out_valid_r;
    logic               out_last_r;
    logic signed [15:0] out_re_r;
    logic signed [15:0] out_im_r;

    logic signed [15:0] buf_re_r [16];
    logic signed [15:0] buf_im_r [16];

    logic               compute_s;
    logic [3:0]         addr_s   [4];
    logic signed [15:0] op_re_s  [4];
    logic signed [15:0] op_im_s  [4];
    logic signed [15:0] bo_re_s  [4];
    logic signed [15:0] bo_im_s  [4];
    logic signed [15:0] res_re_s [4];
    logic signed [15:0] res_im_s [4];
    logic [3:0]         unl_j_s;
    logic [3:0]         unl_addr_s;

`ifdef FFT16_SCHED_TWIDDLE_EN
    logic [3:0]         tw_e_s   [4];

    // Q1.14 coefficients {cos, -sin} of 2*pi*e/16 for exponents 0..9
    function automatic logic [31:0] twiddle_rom(input logic [3:0] e);
        case (e)
            4'd0:    twiddle_rom = {16'h4000, 16'h0000};
            4'd1:    twiddle_rom = {16'h3B21, 16'hE782};
            4'd2:    twiddle_rom = {16'h2D41, 16'hD2BF};
            4'd3:    twiddle_rom = {16'h187E, 16'hC4DF};
            4'd4:    twiddle_rom = {16'h0000, 16'hC000};
            4'd5:    twiddle_rom = {16'hE782, 16'hC4DF};
            4'd6:    twiddle_rom = {16'hD2BF, 16'hD2BF};
            4'd7:    twiddle_rom = {16'hC4DF, 16'hE782};
            4'd8:    twiddle_rom = {16'hC000, 16'h0000};
            4'd9:    twiddle_rom = {16'hC4DF, 16'h187E};
            default: twiddle_rom = {16'h4000, 16'h0000};
        endcase
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [33:0] v);
        if (v > 34'sd32767) begin
            sat16 = 16'sh7FFF;
        end else if (v < -34'sd32768) begin
            sat16 = 16'sh8000;
        end else begin
            sat16 = v[15:0];
        end
    endfunction

    // Complex product, round half up at bit 14, saturated to 16 bits
    function automatic logic [31:0] cmul_q14(input logic signed [15:0] xr,
                                             input logic signed [15:0] xi,
                                             input logic [31:0]        w);
        logic signed [15:0] c;
        logic signed [15:0] s;
        logic signed [33:0] pr;
        logic signed [33:0] pi;
        c  = w[31:16];
        s  = w[15:0];
        pr = 34'(xr) * 34'(c) - 34'(xi) * 34'(s) + 34'sd8192;
        pi = 34'(xr) * 34'(s) + 34'(xi) * 34'(c) + 34'sd8192;
        cmul_q14 = {sat16(pr >>> 14), sat16(pi >>> 14)};
    endfunction
`endif

    // Operand addressing: stage 1 strides by 4, stage 2 reads contiguous groups; results return in place
    always_comb begin
        compute_s = (state_r == ST_S1) || (state_r == ST_S2);
        for (int m = 0; m < 4; m++) begin
            if (state_r == ST_S1) begin
                addr_s[m] = {2'(m), cnt_r[1:0]};
            end else begin
                addr_s[m] = {cnt_r[1:0], 2'(m)};
            end
            if (compute_s) begin
                op_re_s[m] = buf_re_r[addr_s[m]] >>> 2;
                op_im_s[m] = buf_im_r[addr_s[m]] >>> 2;
            end else begin
                op_re_s[m] = 16'sd0;
                op_im_s[m] = 16'sd0;
            end
        end
    end

    // Gather butterfly results and apply the inter-stage twiddle when built in
    always_comb begin
        bo_re_s[0] = bf_o0_re;
        bo_re_s[1] = bf_o1_re;
        bo_re_s[2] = bf_o2_re;
        bo_re_s[3] = bf_o3_re;
        bo_im_s[0] = bf_o0_im;
        bo_im_s[1] = bf_o1_im;
        bo_im_s[2] = bf_o2_im;
        bo_im_s[3] = bf_o3_im;
        for (int k = 0; k < 4; k++) begin
`ifdef FFT16_SCHED_TWIDDLE_EN
            tw_e_s[k] = {2'b00, cnt_r[1:0]} * 4'(k);
            if (state_r == ST_S1) begin
                {res_re_s[k], res_im_s[k]} = cmul_q14(bo_re_s[k], bo_im_s[k], twiddle_rom(tw_e_s[k]));
            end else begin
                res_re_s[k] = bo_re_s[k];
                res_im_s[k] = bo_im_s[k];
            end
`else
            res_re_s[k] = bo_re_s[k];
            res_im_s[k] = bo_im_s[k];
`endif
        end
    end

    // Unload beat j reads the digit-reversed buffer slot
    always_comb begin
        if (out_valid_r) begin
            unl_j_s = j_r + 4'd1;
        end else begin
            unl_j_s = 4'd0;
        end
        unl_addr_s = {unl_j_s[1:0], unl_j_s[3:2]};
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (in_valid && (cnt_r == 4'd15)) begin
                    state_s = ST_S1;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_S1: begin
                if (cnt_r[1:0] == 2'd3) begin
                    state_s = ST_S2;
                end else begin
                    state_s = ST_S1;
                end
            end
            ST_S2: begin
                if (cnt_r[1:0] == 2'd3) begin
                    state_s = ST_UNLOAD;
                end else begin
                    state_s = ST_S2;
                end
            end
            ST_UNLOAD: begin
                if (out_valid_r && out_ready && (j_r == 4'd15)) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_UNLOAD;
                end
            end
            default: state_s = ST_LOAD;
        endcase
    end

    // Control state, counters and registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_LOAD;
            cnt_r       <= 4'd0;
            j_r         <= 4'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_re_r    <= 16'sd0;
            out_im_r    <= 16'sd0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ST_LOAD: begin
                    if (in_valid) begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_S1, ST_S2: begin
                    if (cnt_r[1:0] == 2'd3) begin
                        cnt_r <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        j_r         <= 4'd0;
                        out_last_r  <= 1'b0;
                        out_re_r    <= buf_re_r[unl_addr_s];
                        out_im_r    <= buf_im_r[unl_addr_s];
                    end else if (out_ready) begin
                        if (j_r == 4'd15) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            j_r         <= 4'd0;
                        end else begin
                            j_r         <= unl_j_s;
                            out_last_r  <= (unl_j_s == 4'd15);
                            out_re_r    <= buf_re_r[unl_addr_s];
                            out_im_r    <= buf_im_r[unl_addr_s];
                        end
                    end
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Frame buffer: sample capture and in-place butterfly write-back (contents survive reset)
    always_ff @(posedge clk) begin
        case (state_r)
            ST_LOAD: begin
                if (in_valid) begin
                    buf_re_r[cnt_r] <= in_re;
                    buf_im_r[cnt_r] <= in_im;
                end
            end
            ST_S1, ST_S2: begin
                for (int k = 0; k < 4; k++) begin
                    buf_re_r[addr_s[k]] <= res_re_s[k];
                    buf_im_r[addr_s[k]] <= res_im_s[k];
                end
            end
            default: begin
            end
        endcase
    end

    assign in_ready  = (state_r == ST_LOAD);
    assign busy      = (state_r != ST_LOAD);
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_idx   = j_r;
    assign out_re    = out_re_r;
    assign out_im    = out_im_r;

    assign bf_a_re = op_re_s[0];
    assign bf_b_re = op_re_s[1];
    assign bf_c_re = op_re_s[2];
    assign bf_d_re = op_re_s[3];
    assign bf_a_im = op_im_s[0];
    assign bf_b_im = op_im_s[1];
    assign bf_c_im = op_im_s[2];
    assign bf_d_im = op_im_s[3];

endmodule

// File: tb/tb_fft16_sched.sv
// Self-checking bench for fft16_sched: supplies the radix-4 butterfly and compares frames with a DFT-stage reference model.
`timescale 1ns/1ps
module tb_fft16_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, in_ready, out_valid, out_ready, out_last, busy;
    logic signed [15:0] in_re, in_im, out_re, out_im;
    logic [3:0] out_idx;
    logic signed [15:0] bf_a_re, bf_b_re, bf_c_re, bf_d_re, bf_a_im, bf_b_im, bf_c_im, bf_d_im;
    logic signed [15:0] bo_re [4];
    logic signed [15:0] bo_im [4];

    fft16_sched dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last),
        .bf_a_re(bf_a_re), .bf_b_re(bf_b_re), .bf_c_re(bf_c_re), .bf_d_re(bf_d_re),
        .bf_a_im(bf_a_im), .bf_b_im(bf_b_im), .bf_c_im(bf_c_im), .bf_d_im(bf_d_im),
        .bf_o0_re(bo_re[0]), .bf_o1_re(bo_re[1]), .bf_o2_re(bo_re[2]), .bf_o3_re(bo_re[3]),
        .bf_o0_im(bo_im[0]), .bf_o1_im(bo_im[1]), .bf_o2_im(bo_im[2]), .bf_o3_im(bo_im[3]),
        .busy(busy)
    );

    int checks = 0;
    int failures = 0;
    int xr [16];
    int xi [16];
    int er [16];
    int ei [16];
    int got_re [16];
    int got_im [16];

    // multiply (r + j i) by (-j)^k
    function automatic void rot(input int r, input int i, input int k, output int orr, output int oi);
        case (k % 4)
            0: begin orr = r;  oi = i;  end
            1: begin orr = i;  oi = -r; end
            2: begin orr = -r; oi = -i; end
            default: begin orr = -i; oi = r; end
        endcase
    endfunction

    function automatic int w16(input int v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    // External 4-point DFT butterfly
    int opr [4];
    int opi [4];
    always_comb begin
        int sr, si, tr, ti;
        opr[0] = bf_a_re; opr[1] = bf_b_re; opr[2] = bf_c_re; opr[3] = bf_d_re;
        opi[0] = bf_a_im; opi[1] = bf_b_im; opi[2] = bf_c_im; opi[3] = bf_d_im;
        for (int k = 0; k < 4; k++) begin
            sr = 0; si = 0;
            for (int m = 0; m < 4; m++) begin
                rot(opr[m], opi[m], m * k, tr, ti);
                sr = sr + tr; si = si + ti;
            end
            bo_re[k] = 16'(sr);
            bo_im[k] = 16'(si);
        end
    end

    function automatic int sat(input longint v);
        if (v > 32767) return 32767;
        else if (v < -32768) return -32768;
        else return int'(v);
    endfunction

    // Reference: 16 = 4x4 decomposition, each 4-point DFT on inputs scaled by 1/4
    task automatic model();
        int yr [4][4];
        int yi [4][4];
        int sr, si, tr, ti;
        for (int n1 = 0; n1 < 4; n1++) begin
            for (int k2 = 0; k2 < 4; k2++) begin
                sr = 0; si = 0;
                for (int m = 0; m < 4; m++) begin
                    rot(xr[n1 + 4 * m] >>> 2, xi[n1 + 4 * m] >>> 2, m * k2, tr, ti);
                    sr += tr; si += ti;
                end
                sr = w16(sr); si = w16(si);
`ifdef FFT16_SCHED_TWIDDLE_EN
                begin
                    real ang, cr, cs;
                    longint c, s, pr, pi;
                    ang = 2.0 * 3.14159265358979 * real'(n1 * k2) / 16.0;
                    cr = 16384.0 * $cos(ang);
                    cs = -16384.0 * $sin(ang);
                    c = longint'($rtoi(cr + ((cr >= 0.0) ? 0.5 : -0.5)));
                    s = longint'($rtoi(cs + ((cs >= 0.0) ? 0.5 : -0.5)));
                    pr = longint'(sr) * c - longint'(si) * s;
                    pi = longint'(sr) * s + longint'(si) * c;
                    sr = sat((pr + 8192) >>> 14);
                    si = sat((pi + 8192) >>> 14);
                end
`endif
                yr[n1][k2] = sr; yi[n1][k2] = si;
            end
        end
        for (int k2 = 0; k2 < 4; k2++) begin
            for (int k1 = 0; k1 < 4; k1++) begin
                sr = 0; si = 0;
                for (int n1 = 0; n1 < 4; n1++) begin
                    rot(yr[n1][k2] >>> 2, yi[n1][k2] >>> 2, n1 * k1, tr, ti);
                    sr += tr; si += ti;
                end
                er[4 * k1 + k2] = w16(sr);
                ei[4 * k1 + k2] = w16(si);
            end
        end
    endtask

    task automatic send_frame();
        int guard;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re = 16'(xr[i]);
            in_im = 16'(xi[i]);
            guard = 0;
            while (!in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) begin
                checks++; failures++;
                $display("FAIL send_timeout beat=%0d in_ready=%b required=1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv_frame(input int stall_at, input int stall_len);
        int guard;
        logic [36:0] exp_v, held_v;
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            guard = 0;
            while (!out_valid && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!out_valid) begin
                checks++; failures++;
                $display("FAIL recv_timeout beat=%0d out_valid=%b required=1", j, out_valid);
                return;
            end
            exp_v = {16'(er[j]), 16'(ei[j]), 4'(j), (j == 15)};
            checks++;
            if ({out_re, out_im, out_idx, out_last} !== exp_v) begin
                failures++;
                $display("FAIL bin%0d got re=%h im=%h idx=%0d last=%b required re=%h im=%h idx=%0d last=%b",
                         j, out_re, out_im, out_idx, out_last, exp_v[36:21], exp_v[20:5], exp_v[4:1], exp_v[0]);
            end
            got_re[j] = out_re;
            got_im[j] = out_im;
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL unload_flags bin%0d in_ready=%b busy=%b required 0/1", j, in_ready, busy);
            end
            if (j == 0) begin
                checks++;
                if ({bf_a_re, bf_b_re, bf_c_re, bf_d_re, bf_a_im, bf_b_im, bf_c_im, bf_d_im} !== 128'd0) begin
                    failures++;
                    $display("FAIL bf_idle_zero got a_re=%h a_im=%h required 0", bf_a_re, bf_a_im);
                end
            end
            if (j == stall_at) begin
                held_v = {out_re, out_im, out_idx, 1'b1};
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || {out_re, out_im, out_idx, 1'b1} !== held_v || in_ready !== 1'b0) begin
                        failures++;
                        $display("FAIL stall_hold cyc=%0d got v=%b re=%h im=%h idx=%0d in_ready=%b required v=1 re=%h im=%h idx=%0d in_ready=0",
                                 s, out_valid, out_re, out_im, out_idx, in_ready, held_v[36:21], held_v[20:5], held_v[4:1]);
                    end
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL back_to_load in_ready=%b out_valid=%b busy=%b required 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) begin
            xr[i] = 0; xi[i] = 0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_last, out_idx, out_re, out_im, busy, in_ready} !== {1'b0, 1'b0, 4'd0, 16'd0, 16'd0, 1'b0, 1'b1}
            || {bf_a_re, bf_b_re, bf_c_re, bf_d_re, bf_a_im, bf_b_im, bf_c_im, bf_d_im} !== 128'd0) begin
            failures++;
            $display("FAIL reset_state v=%b last=%b idx=%0d re=%h im=%h busy=%b in_ready=%b required zeros with in_ready=1",
                     out_valid, out_last, out_idx, out_re, out_im, busy, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        set_zero();
        xr[0] = 32'h4000;
        model();
        send_frame();
        recv_frame(-1, 0);
        for (int j = 0; j < 16; j += 5) begin
            checks++;
            if (got_re[j] !== 32'h0400 || got_im[j] !== 0) begin
                failures++;
                $display("FAIL impulse_bin%0d got (%h,%h) required (0400,0000)", j, got_re[j], got_im[j]);
            end
        end
    endtask

    task automatic test_dc();
        for (int i = 0; i < 16; i++) begin
            xr[i] = 32'h0400; xi[i] = 0;
        end
        model();
        send_frame();
        recv_frame(-1, 0);
        checks++;
        if (got_re[0] !== 32'h0400 || got_im[0] !== 0 || got_re[9] !== 0 || got_im[15] !== 0) begin
            failures++;
            $display("FAIL dc got X0=(%h,%h) X9re=%h X15im=%h required (0400,0) 0 0", got_re[0], got_im[0], got_re[9], got_im[15]);
        end
    endtask

    task automatic test_twiddle();
        set_zero();
        xr[1] = 32'h4000;
        model();
        send_frame();
        recv_frame(-1, 0);
        checks++;
`ifdef FFT16_SCHED_TWIDDLE_EN
        if (got_re[2] !== 32'h02D4 || got_im[2] !== -32'sh02D4 || got_re[4] !== 0 || got_im[4] !== -32'sh0400) begin
            failures++;
            $display("FAIL twiddle got X2=(%0d,%0d) X4=(%0d,%0d) required (724,-724) (0,-1024)", got_re[2], got_im[2], got_re[4], got_im[4]);
        end
`else
        if (got_re[2] !== 32'h0400 || got_im[2] !== 0) begin
            failures++;
            $display("FAIL twiddle_bypass got X2=(%0d,%0d) required (1024,0)", got_re[2], got_im[2]);
        end
`endif
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 16; i++) begin
            xr[i] = int'($signed(16'($urandom))); xi[i] = int'($signed(16'($urandom)));
        end
        model();
        send_frame();
        recv_frame(7, 5);
    endtask

    task automatic test_latency();
        set_zero();
        xr[3] = 1000; xi[5] = -2000;
        model();
        send_frame();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (k == 9) || busy !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL latency after T+%0d out_valid=%b busy=%b in_ready=%b required %b/1/0", k, out_valid, busy, in_ready, (k == 9));
            end
        end
        recv_frame(-1, 0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) begin
            xr[i] = 1234 * i; xi[i] = -77 * i;
        end
        send_frame();
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || bf_a_re !== 16'sd0 || out_idx !== 4'd0) begin
            failures++;
            $display("FAIL reset_mid out_valid=%b busy=%b in_ready=%b bf_a_re=%h idx=%0d required 0/0/1/0/0",
                     out_valid, busy, in_ready, bf_a_re, out_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_impulse();
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 16; i++) begin
                if (f == 0) begin
                    xr[i] = int'($urandom_range(0, 2000)) - 1000;
                    xi[i] = int'($urandom_range(0, 2000)) - 1000;
                end else begin
                    xr[i] = int'($signed(16'($urandom)));
                    xi[i] = int'($signed(16'($urandom)));
                end
            end
            model();
            send_frame();
            recv_frame(int'($urandom_range(0, 15)), int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        in_valid = 1'b0; in_re = 16'sd0; in_im = 16'sd0; out_ready = 1'b1;
        test_reset();
        test_impulse();
        test_dc();
        test_twiddle();
        test_latency();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
